// File: rtl/game_pos_updater.sv
// game_pos_updater
//   Per-frame game-state engine ahead of the VGA sprite renderer. On each
//   frame_tick it scrolls the cactus, steps the man's jump physics and
//   counts the frame. It then writes cactus X and man Y to two consecutive
//   RAM words, and checks for a collision between the two sprites.
//
// Ports
//   pix_clk    pixel clock
//   reset      synchronous, active-high
//   frame_tick one-cycle pulse per frame; starts an update sequence
//   jump_btn   asynchronous level input, active-high
//   restart    one-cycle pulse; reinitialises game state, aborts a sequence
//   ram_addr   RAM write address (POS_BASE, POS_BASE+1)
//   ram_we     RAM write enable
//   ram_d      RAM write data (zero-extended position)
//   cactus_x   current cactus X
//   man_y      current man Y
//   game_over  latched collision flag
//   busy       high during CALC, WR_X and WR_Y
//   score      frames survived, saturating
module game_pos_updater #(
  parameter int                    ADDR_WIDTH     = 16,
  parameter logic [ADDR_WIDTH-1:0] POS_BASE       = 16'h8000,
  parameter logic [9:0]            MAN_X_FIXED    = 10'd0,
  parameter logic [9:0]            CACTUS_Y_FIXED = 10'd300,
  parameter logic [9:0]            GROUND_Y       = 10'd300,
  parameter logic [7:0]            JUMP_VEL       = 8'd20,
  parameter logic [7:0]            GRAVITY        = 8'd1,
  parameter logic [9:0]            CACTUS_SPEED   = 10'd4,
  parameter logic [9:0]            CACTUS_X_START = 10'd639,
  parameter logic [9:0]            BOX            = 10'd96
) (
  input  logic                  pix_clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  input  logic                  jump_btn,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [15:0]           ram_d,
  output logic [9:0]            cactus_x,
  output logic [9:0]            man_y,
  output logic                  game_over,
  output logic                  busy,
  output logic [15:0]           score
);

  typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

  state_t state, state_nxt;

  logic signed [7:0]  vel;
  logic               grounded;
  logic               jump_pending;
  logic               jump_p0, jump_p1, jump_p2;
  logic               jump_rise;

  logic [9:0]         cactus_x_nxt;
  logic [9:0]         man_y_nxt;
  logic signed [7:0]  vel_nxt;
  logic               grounded_nxt;
  logic signed [11:0] cand;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Overlap test on 11-bit operands so x+BOX never wraps.
  function automatic logic collide(input logic [9:0] cx, input logic [9:0] my);
    logic [10:0] cx_w, my_w, mx_w, cy_w, box_w;
    cx_w  = {1'b0, cx};
    my_w  = {1'b0, my};
    mx_w  = {1'b0, MAN_X_FIXED};
    cy_w  = {1'b0, CACTUS_Y_FIXED};
    box_w = {1'b0, BOX};
    return (cx_w < mx_w + box_w) && (mx_w < cx_w + box_w) &&
           (my_w < cy_w + box_w) && (cy_w < my_w + box_w);
  endfunction

  // Stage p0/p1: two-flop synchroniser; p2 holds the previous synced level.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      jump_p0 <= 1'b0;
      jump_p1 <= 1'b0;
      jump_p2 <= 1'b0;
    end else begin
      jump_p0 <= jump_btn;
      jump_p1 <= jump_p0;
      jump_p2 <= jump_p1;
    end
  end

  assign jump_rise = jump_p1 & ~jump_p2;

  always_ff @(posedge pix_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_tick) state_nxt = CALC;
      CALC:    state_nxt = WR_X;
      WR_X:    state_nxt = WR_Y;
      WR_Y:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // restart wins over a coincident frame_tick and aborts any sequence
    if (restart) state_nxt = IDLE;
  end

  always_comb begin
    busy     = (state != IDLE);
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_d    = '0;
    case (state)
      WR_X: begin
        ram_we   = 1'b1;
        ram_addr = POS_BASE;
        ram_d    = {6'b0, cactus_x};
      end
      WR_Y: begin
        ram_we   = 1'b1;
        ram_addr = POS_BASE + ADDR_WIDTH'(1);
        ram_d    = {6'b0, man_y};
      end
      default: ;
    endcase
  end

  always_comb begin
    cactus_x_nxt = (cactus_x < CACTUS_SPEED) ? CACTUS_X_START : cactus_x - CACTUS_SPEED;
    man_y_nxt    = man_y;
    vel_nxt      = vel;
    grounded_nxt = grounded;
    cand         = $signed({2'b00, man_y}) - $signed({{4{vel[7]}}, vel});
    if (grounded) begin
      if (jump_pending) begin
        vel_nxt      = $signed(JUMP_VEL);
        grounded_nxt = 1'b0;
      end
    end else if (cand >= $signed({2'b00, GROUND_Y})) begin
      man_y_nxt    = GROUND_Y;
      vel_nxt      = 8'sd0;
      grounded_nxt = 1'b1;
    end else if (cand[11]) begin
      man_y_nxt = 10'd0;
      vel_nxt   = vel - $signed(GRAVITY);
    end else begin
      man_y_nxt = cand[9:0];
      vel_nxt   = vel - $signed(GRAVITY);
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset || restart) begin
      cactus_x     <= CACTUS_X_START;
      man_y        <= GROUND_Y;
      vel          <= 8'sd0;
      grounded     <= 1'b1;
      jump_pending <= 1'b0;
      game_over    <= 1'b0;
      score        <= 16'd0;
    end else begin
      if (state == CALC)  jump_pending <= 1'b0;
      else if (jump_rise) jump_pending <= 1'b1;
      if (state == CALC && !game_over) begin
        cactus_x <= cactus_x_nxt;
        man_y    <= man_y_nxt;
        vel      <= vel_nxt;
        grounded <= grounded_nxt;
        score    <= sat_inc16(score);
      end
      // Collision sees the positions just committed in CALC.
      if (state == WR_X && collide(cactus_x, man_y)) game_over <= 1'b1;
    end
  end

endmodule

// File: tb/tb_game_pos_updater.sv
module tb_game_pos_updater;

  localparam int GROUND  = 300;
  localparam int X_START = 639;
  localparam int SPEED   = 4;
  localparam int JV      = 20;
  localparam int GRAV    = 1;
  localparam int MX      = 0;
  localparam int CY      = 300;
  localparam int BX      = 96;

  logic        pix_clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        frame_tick_w = 1'b0;
  logic        jump_btn = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_d;
  logic [9:0]  cactus_x;
  logic [9:0]  man_y;
  logic        game_over;
  logic        busy;
  logic [15:0] score;

  logic [15:0] ram_addr_w;
  logic        ram_we_w;
  logic [15:0] ram_d_w;
  logic [9:0]  cactus_x_w;
  logic [9:0]  man_y_w;
  logic        game_over_w;
  logic        busy_w;
  logic [15:0] score_w;

  always #5 pix_clk = ~pix_clk;

  game_pos_updater u_dut (
    .pix_clk(pix_clk), .reset(reset), .frame_tick(frame_tick),
    .jump_btn(jump_btn), .restart(restart),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_d(ram_d),
    .cactus_x(cactus_x), .man_y(man_y), .game_over(game_over),
    .busy(busy), .score(score)
  );

  // Collision masked: cactus sits at Y=0 with a tiny box.
  game_pos_updater #(.CACTUS_Y_FIXED(10'd0), .BOX(10'd10)) u_wrap (
    .pix_clk(pix_clk), .reset(reset), .frame_tick(frame_tick_w),
    .jump_btn(1'b0), .restart(1'b0),
    .ram_addr(ram_addr_w), .ram_we(ram_we_w), .ram_d(ram_d_w),
    .cactus_x(cactus_x_w), .man_y(man_y_w), .game_over(game_over_w),
    .busy(busy_w), .score(score_w)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int wr_count = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_e;

  int m_cx, m_my, m_vel, m_gnd, m_pend, m_go, m_score;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge pix_clk) begin
    if (ram_we === 1'b1) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("wr_addr", int'(ram_addr), int'(mon_e[31:16]));
        check_val("wr_data", int'(ram_d), int'(mon_e[15:0]));
      end
    end
  end

  task automatic model_reset();
    m_cx = X_START; m_my = GROUND; m_vel = 0; m_gnd = 1;
    m_pend = 0; m_go = 0; m_score = 0;
  endtask

  task automatic model_frame();
    int cand;
    if (m_go == 0) begin
      m_cx = (m_cx < SPEED) ? X_START : m_cx - SPEED;
      if (m_gnd == 1) begin
        if (m_pend == 1) begin
          m_vel = JV;
          m_gnd = 0;
        end
      end else begin
        cand = m_my - m_vel;
        if (cand >= GROUND) begin
          m_my = GROUND; m_vel = 0; m_gnd = 1;
        end else if (cand < 0) begin
          m_my = 0; m_vel = m_vel - GRAV;
        end else begin
          m_my = cand; m_vel = m_vel - GRAV;
        end
      end
      if (m_score < 65535) m_score++;
    end
    m_pend = 0;
    exp_q.push_back({16'h8000, 16'(m_cx)});
    exp_q.push_back({16'h8001, 16'(m_my)});
    if ((m_cx < MX + BX) && (MX < m_cx + BX) && (m_my < CY + BX) && (CY < m_my + BX))
      m_go = 1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 8) begin
      @(negedge pix_clk);
      n++;
    end
    if (busy !== 1'b0) check_val({tag, "_busy_timeout"}, 1, 0);
  endtask

  task automatic tick_main();
    @(negedge pix_clk);
    frame_tick = 1'b1;
    model_frame();
    @(negedge pix_clk);
    frame_tick = 1'b0;
    wait_idle("tick");
  endtask

  task automatic do_reset();
    @(negedge pix_clk);
    reset = 1'b1; frame_tick = 1'b0; frame_tick_w = 1'b0;
    jump_btn = 1'b0; restart = 1'b0;
    @(negedge pix_clk);
    check_val("rst_cactus_x", int'(cactus_x), X_START);
    check_val("rst_man_y", int'(man_y), GROUND);
    check_val("rst_game_over", int'(game_over), 0);
    check_val("rst_score", int'(score), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ram_we", int'(ram_we), 0);
    check_val("rst_ram_addr", int'(ram_addr), 0);
    check_val("rst_ram_d", int'(ram_d), 0);
    reset = 1'b0;
    model_reset();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_wr;
    int j;

    // 1: single frame, latency and write contents
    do_reset();
    @(negedge pix_clk);
    frame_tick = 1'b1;
    model_frame();
    @(negedge pix_clk);
    frame_tick = 1'b0;
    check_val("t1_calc_busy", int'(busy), 1);
    check_val("t1_calc_we", int'(ram_we), 0);
    @(negedge pix_clk);
    check_val("t1_wrx_we", int'(ram_we), 1);
    check_val("t1_wrx_addr", int'(ram_addr), 16'h8000);
    check_val("t1_wrx_d", int'(ram_d), 635);
    check_val("t1_wrx_busy", int'(busy), 1);
    @(negedge pix_clk);
    check_val("t1_wry_we", int'(ram_we), 1);
    check_val("t1_wry_addr", int'(ram_addr), 16'h8001);
    check_val("t1_wry_d", int'(ram_d), 300);
    check_val("t1_wry_busy", int'(busy), 1);
    @(negedge pix_clk);
    check_val("t1_done_busy", int'(busy), 0);
    check_val("t1_done_we", int'(ram_we), 0);

    // 3: jump arc
    do_reset();
    jump_btn = 1'b1;
    repeat (4) @(negedge pix_clk);
    jump_btn = 1'b0;
    m_pend = 1;
    for (int k = 1; k <= 43; k++) begin
      tick_main();
      j = k - 1;
      if (k == 1 || k == 2 || k == 21 || k == 41 || k == 42)
        check_val($sformatf("t3_man_y_tick%0d", k), int'(man_y), 300 - (20 * j - j * (j - 1) / 2));
      if (k == 43) check_val("t3_man_y_landed", int'(man_y), 300);
    end

    // 2: scroll into the man, then freeze
    do_reset();
    for (int k = 1; k <= 140; k++) begin
      tick_main();
      if (k == 135) begin
        check_val("t2_cx_135", int'(cactus_x), 99);
        check_val("t2_go_135", int'(game_over), 0);
      end
      if (k == 136) begin
        check_val("t2_cx_136", int'(cactus_x), 95);
        check_val("t2_go_136", int'(game_over), 1);
        check_val("t2_score_136", int'(score), 136);
      end
      if (k == 140) begin
        check_val("t2_cx_frozen", int'(cactus_x), 95);
        check_val("t2_score_frozen", int'(score), 136);
        check_val("t2_go_held", int'(game_over), 1);
      end
    end

    // 6: restart during WR_X after game over
    @(negedge pix_clk);
    frame_tick = 1'b1;
    exp_q.push_back({16'h8000, 16'(m_cx)});
    @(negedge pix_clk);
    frame_tick = 1'b0;
    @(negedge pix_clk);
    check_val("t6_wrx_we", int'(ram_we), 1);
    restart = 1'b1;
    @(negedge pix_clk);
    restart = 1'b0;
    model_reset();
    check_val("t6_we_dropped", int'(ram_we), 0);
    check_val("t6_busy", int'(busy), 0);
    check_val("t6_cactus_x", int'(cactus_x), 639);
    check_val("t6_man_y", int'(man_y), 300);
    check_val("t6_game_over", int'(game_over), 0);
    check_val("t6_score", int'(score), 0);
    repeat (3) @(negedge pix_clk);

    // 5: ticks while busy are ignored
    start_wr = wr_count;
    @(negedge pix_clk);
    frame_tick = 1'b1;
    model_frame();
    @(negedge pix_clk);
    check_val("t5_calc_busy", int'(busy), 1);
    @(negedge pix_clk);
    frame_tick = 1'b0;
    @(negedge pix_clk);
    frame_tick = 1'b1;
    @(negedge pix_clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge pix_clk);
    check_val("t5_write_count", wr_count - start_wr, 2);
    check_val("t5_idle", int'(busy), 0);
    check_val("t5_cactus_x", int'(cactus_x), 635);

    // 4: cactus wrap on the collision-masked instance
    do_reset();
    for (int k = 1; k <= 160; k++) begin
      @(negedge pix_clk);
      frame_tick_w = 1'b1;
      @(negedge pix_clk);
      frame_tick_w = 1'b0;
      repeat (4) @(negedge pix_clk);
      if (k == 159) check_val("t4_cx_159", int'(cactus_x_w), 3);
      if (k == 160) begin
        check_val("t4_cx_wrap", int'(cactus_x_w), 639);
        check_val("t4_no_go", int'(game_over_w), 0);
        check_val("t4_score", int'(score_w), 160);
      end
    end

    check_val("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
